mux_addr_pipe: RTL and testbench

MUX_ADDR_PIPE -- requirements
Module: mux_addr_pipe

---
 rtl/mux_addr_pipe.sv | 133 +++++++++++++
 tb/tb_mux_addr_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_addr_pipe.sv
// mux_addr_pipe: selects one of NUM_IN address channels on each accepted input
// item and forwards it through a two-entry pipe (output register plus skid
// register). Zero addresses can be suppressed and are counted. An item whose
// select is out of range is dropped and raises a sticky error flag.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset
//   in_data    NUM_IN packed channels, channel k = in_data[k*WIDTH +: WIDTH]
//   in_sel     binary channel select
//   in_valid   upstream item present
//   in_ready   registered; high while the skid register is empty
//   out_data   selected address
//   out_valid  out_data holds an item
//   out_ready  downstream accepts
//   drop_cnt   saturating count of suppressed zero items
//   sel_err    sticky: an accepted item had in_sel >= NUM_IN
module mux_addr_pipe #(
    parameter int WIDTH         = 5,
    parameter int NUM_IN        = 4,
    parameter int SUPPRESS_ZERO = 1,
    localparam int SEL_W        = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             drop_cnt,
    output logic                    sel_err
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic             sel_err_q, sel_err_d;

    logic [WIDTH-1:0] sel_val;
    logic             sel_ok;
    logic             suppress;
    logic             accept;
    logic             fwd;
    logic             xfer;

    // Channel select; an out-of-range select matches no channel and leaves
    // sel_ok low, so non-power-of-two NUM_IN needs no extra compare.
    always_comb begin
        sel_val = '0;
        sel_ok  = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_val = in_data[k*WIDTH +: WIDTH];
                sel_ok  = 1'b1;
            end
        end
    end

    assign suppress = (SUPPRESS_ZERO != 0) && (sel_val == '0);
    assign accept   = in_valid && in_ready_q;
    assign fwd      = accept && sel_ok && !suppress;
    assign xfer     = out_valid_q && out_ready;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        drop_cnt_d   = drop_cnt_q;
        sel_err_d    = sel_err_q | (accept && !sel_ok);

        if (skid_valid_q) begin
            // in_ready is low here, so no new item can arrive this cycle.
            if (xfer) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end
        end else if (out_valid_q && !xfer) begin
            if (fwd) begin
                skid_d       = sel_val;
                skid_valid_d = 1'b1;
            end
        end else begin
            // Output register is empty or draining this cycle.
            if (fwd) begin
                out_d       = sel_val;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        if (accept && sel_ok && suppress && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            drop_cnt_q   <= '0;
            sel_err_q    <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            drop_cnt_q   <= drop_cnt_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_q;
    assign out_valid = out_valid_q;
    assign drop_cnt  = drop_cnt_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_addr_pipe.sv
module tb_mux_addr_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        out_ready;

    // dut0: defaults; dut1: SUPPRESS_ZERO=0; dut2: NUM_IN=3 (shared stimulus)
    logic [4:0]  o0_data, o1_data, o2_data;
    logic        o0_valid, o1_valid, o2_valid;
    logic        i0_ready, i1_ready, i2_ready;
    logic [15:0] d0_cnt, d1_cnt, d2_cnt;
    logic        e0_err, e1_err, e2_err;

    // dut3: WIDTH=8, NUM_IN=16, random traffic
    logic [127:0] r_data;
    logic [3:0]   r_sel;
    logic         r_valid;
    logic         r_ready;
    logic [7:0]   r_odata;
    logic         r_ovalid;
    logic         r_iready;
    logic [15:0]  r_drop;
    logic         r_selerr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_addr_pipe dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(i0_ready), .out_data(o0_data),
        .out_valid(o0_valid), .out_ready(out_ready), .drop_cnt(d0_cnt),
        .sel_err(e0_err)
    );

    mux_addr_pipe #(.SUPPRESS_ZERO(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(i1_ready), .out_data(o1_data),
        .out_valid(o1_valid), .out_ready(out_ready), .drop_cnt(d1_cnt),
        .sel_err(e1_err)
    );

    mux_addr_pipe #(.NUM_IN(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[14:0]), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(i2_ready), .out_data(o2_data),
        .out_valid(o2_valid), .out_ready(out_ready), .drop_cnt(d2_cnt),
        .sel_err(e2_err)
    );

    mux_addr_pipe #(.WIDTH(8), .NUM_IN(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(r_data), .in_sel(r_sel),
        .in_valid(r_valid), .in_ready(r_iready), .out_data(r_odata),
        .out_valid(r_ovalid), .out_ready(r_ready), .drop_cnt(r_drop),
        .sel_err(r_selerr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] q[$];
    logic [7:0] sv;
    logic [7:0] exp_v;
    int         exp_drop = 0;

    initial begin
        rst_n = 1'b0; in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = 1'b0;
        r_data = '0; r_sel = '0; r_valid = 1'b0; r_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;

        check("rst_out_valid", o0_valid, 0);
        check("rst_out_data",  o0_data,  0);
        check("rst_in_ready",  i0_ready, 1);
        check("rst_drop_cnt",  d0_cnt,   0);
        check("rst_sel_err",   e0_err,   0);

        // Basic select: channel 2 holds 7
        in_data = {5'd9, 5'd7, 5'd3, 5'd12}; in_sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("basic_no_comb_path", o0_valid, 0);
        step();
        in_valid = 1'b0;
        check("basic_valid", o0_valid, 1);
        check("basic_data",  o0_data,  7);
        check("basic_n3_data", o2_data, 7);
        step();
        check("basic_one_cycle", o0_valid, 0);

        // Backpressure: 4,5 stored, 6 held off, then released in order
        out_ready = 1'b0; in_sel = 2'd0; in_valid = 1'b1;
        in_data = {5'd9, 5'd7, 5'd3, 5'd4};
        step();
        check("bp_ready_after_1", i0_ready, 1);
        check("bp_out_4", o0_data, 4);
        in_data = {5'd9, 5'd7, 5'd3, 5'd5};
        step();
        check("bp_ready_after_2", i0_ready, 0);
        in_data = {5'd9, 5'd7, 5'd3, 5'd6};
        step();
        check("bp_held_ready", i0_ready, 0);
        check("bp_hold_data",  o0_data,  4);
        check("bp_hold_valid", o0_valid, 1);
        step();
        check("bp_hold_data2", o0_data, 4);
        out_ready = 1'b1;
        step();
        check("bp_out_5", o0_data, 5);
        check("bp_ready_back", i0_ready, 1);
        step();
        in_valid = 1'b0;
        check("bp_out_6", o0_data, 6);
        check("bp_out_6_valid", o0_valid, 1);
        step();
        check("bp_drained", o0_valid, 0);

        // Zero selection: suppressed on dut0/dut2, forwarded on dut1
        in_data = {5'd9, 5'd7, 5'd0, 5'd12}; in_sel = 2'd1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("zero_sup_no_valid", o0_valid, 0);
            check("zero_fwd_valid",    o1_valid, 1);
            check("zero_fwd_data",     o1_data,  0);
        end
        in_valid = 1'b0;
        check("zero_drop_cnt",     d0_cnt, 3);
        check("zero_fwd_drop_cnt", d1_cnt, 0);
        check("zero_n3_drop_cnt",  d2_cnt, 3);
        step();
        check("zero_fwd_end", o1_valid, 0);

        // Out-of-range select on NUM_IN=3
        in_data = {5'd9, 5'd7, 5'd3, 5'd12}; in_sel = 2'd3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("selerr_set",      e2_err,   1);
        check("selerr_no_out",   o2_valid, 0);
        check("selerr_drop_cnt", d2_cnt,   3);
        check("sel3_legal_n4",   o0_data,  9);
        check("sel3_no_err_n4",  e0_err,   0);
        step(); step();
        check("selerr_sticky", e2_err, 1);

        // Dropped item while output drains
        in_data = {5'd9, 5'd7, 5'd3, 5'd12}; in_sel = 2'd0; in_valid = 1'b1;
        step();
        check("dropx_load", o0_data, 12);
        in_data = {5'd9, 5'd7, 5'd0, 5'd12}; in_sel = 2'd1;
        step();
        in_valid = 1'b0;
        check("dropx_empty", o0_valid, 0);
        check("dropx_cnt",   d0_cnt,   4);

        // Reset with two items stored
        out_ready = 1'b0; in_sel = 2'd0; in_valid = 1'b1;
        in_data = {5'd9, 5'd7, 5'd3, 5'd10};
        step();
        in_data = {5'd9, 5'd7, 5'd3, 5'd11};
        step();
        check("mid_full", i0_ready, 0);
        check("mid_data", o0_data,  10);
        rst_n = 1'b0; in_data = {5'd9, 5'd7, 5'd3, 5'd13};
        step();
        rst_n = 1'b1; in_valid = 1'b0;
        check("mid_rst_valid",   o0_valid, 0);
        check("mid_rst_data",    o0_data,  0);
        check("mid_rst_ready",   i0_ready, 1);
        check("mid_rst_drop",    d0_cnt,   0);
        check("mid_rst_sel_err", e2_err,   0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_no_stale", o0_valid, 0);
        end

        // Random traffic on the wide instance with an in-order scoreboard
        for (int n = 0; n < 800; n++) begin
            r_valid = 1'($urandom_range(0, 1));
            r_ready = ($urandom_range(0, 3) != 0);
            r_sel   = 4'($urandom_range(0, 15));
            for (int k = 0; k < 16; k++)
                r_data[k*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            #1;
            if (r_ovalid && r_ready) begin
                if (q.size() == 0) check("rnd_spurious", r_ovalid, 0);
                else begin
                    exp_v = q.pop_front();
                    check("rnd_data", r_odata, exp_v);
                end
            end
            if (r_valid && r_iready) begin
                sv = r_data[r_sel*8 +: 8];
                if (sv == 8'd0) exp_drop++;
                else q.push_back(sv);
            end
            step();
        end
        r_valid = 1'b0; r_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            #1;
            if (r_ovalid) begin
                if (q.size() == 0) check("rnd_spurious", r_ovalid, 0);
                else begin
                    exp_v = q.pop_front();
                    check("rnd_data", r_odata, exp_v);
                end
            end
            step();
        end
        check("rnd_leftover", q.size(), 0);
        check("rnd_drop_cnt", r_drop, exp_drop);
        check("rnd_sel_err",  r_selerr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
